// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if
//   Bundles the requester-side (consumer_*) and memory-side (mem_*) buses of
//   the arbiter. Consumer k occupies slice [k*W +: W] of each flat vector.
//   Memory channel c likewise occupies slice [c*W +: W].
//   Modports:
//     slave  - the arbiter's view: answers consumers and drives memory requests
//     master - the environment's view: the requesters plus the external memory
interface mem_request_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]            mem_write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]            mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
//   Serves NUM_CONSUMERS load/store requesters over NUM_CHANNELS external
//   memory channels. Each channel runs its own small FSM; the top allocates
//   idle channels to unclaimed requesters in fixed priority (lowest consumer
//   index first, channels filled in index order) and merges the per-channel
//   responses back onto the consumer vectors.
//   Ports:
//     clk, reset - clock, synchronous active-high reset
//     bus        - mem_request_arbiter_if.slave (consumer and memory buses)

// One memory channel: IDLE -> *_WAITING -> *_RELAYING -> IDLE.
// grant_oh is the one-hot consumer handed to this channel in the current
// cycle (only ever non-zero while idle); claim_oh is the registered owner.
module mem_request_arbiter_channel #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CONSUMERS-1:0]       grant_oh,
    input  logic [NUM_CONSUMERS-1:0]       consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    input  logic [NUM_CONSUMERS-1:0]       consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic                           idle,
    output logic [NUM_CONSUMERS-1:0]       claim_oh,
    output logic                           read_ready,
    output logic [DATA_BITS-1:0]           read_data,
    output logic                           write_ready,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready
);
    typedef enum logic [2:0] {
        IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
    } state_t;

    state_t                   state_q, state_n;
    logic [NUM_CONSUMERS-1:0] claim_q, claim_n;
    logic                     mrv_q, mrv_n, mwv_q, mwv_n;
    logic [ADDR_BITS-1:0]     mra_q, mra_n, mwa_q, mwa_n;
    logic [DATA_BITS-1:0]     mwd_q, mwd_n, rdat_q, rdat_n;
    logic                     rrdy_q, rrdy_n, wrdy_q, wrdy_n;

    // One-hot muxes: the granted consumer's request and the owner's valids.
    logic                 sel_rv, cur_rv, cur_wv;
    logic [ADDR_BITS-1:0] sel_ra, sel_wa;
    logic [DATA_BITS-1:0] sel_wd;

    always_comb begin
        sel_rv = |(grant_oh & consumer_read_valid);
        cur_rv = |(claim_q & consumer_read_valid);
        cur_wv = |(claim_q & consumer_write_valid);
        sel_ra = '0;
        sel_wa = '0;
        sel_wd = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            if (grant_oh[k]) begin
                sel_ra = sel_ra | consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
                sel_wa = sel_wa | consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
                sel_wd = sel_wd | consumer_write_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            claim_q <= '0;
            mrv_q   <= 1'b0;
            mra_q   <= '0;
            mwv_q   <= 1'b0;
            mwa_q   <= '0;
            mwd_q   <= '0;
            rrdy_q  <= 1'b0;
            rdat_q  <= '0;
            wrdy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            claim_q <= claim_n;
            mrv_q   <= mrv_n;
            mra_q   <= mra_n;
            mwv_q   <= mwv_n;
            mwa_q   <= mwa_n;
            mwd_q   <= mwd_n;
            rrdy_q  <= rrdy_n;
            rdat_q  <= rdat_n;
            wrdy_q  <= wrdy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        claim_n = claim_q;
        mrv_n   = mrv_q;
        mra_n   = mra_q;
        mwv_n   = mwv_q;
        mwa_n   = mwa_q;
        mwd_n   = mwd_q;
        rrdy_n  = rrdy_q;
        rdat_n  = rdat_q;
        wrdy_n  = wrdy_q;
        case (state_q)
            IDLE: begin
                // Read wins when a consumer raises both valids.
                if (|grant_oh) begin
                    if (sel_rv) begin
                        claim_n = grant_oh;
                        mrv_n   = 1'b1;
                        mra_n   = sel_ra;
                        state_n = READ_WAITING;
                    end else if (WRITE_ENABLE != 0) begin
                        claim_n = grant_oh;
                        mwv_n   = 1'b1;
                        mwa_n   = sel_wa;
                        mwd_n   = sel_wd;
                        state_n = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mrv_n   = 1'b0;
                    mra_n   = '0;
                    rrdy_n  = 1'b1;
                    rdat_n  = mem_read_data;
                    state_n = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mwv_n   = 1'b0;
                    mwa_n   = '0;
                    mwd_n   = '0;
                    wrdy_n  = 1'b1;
                    state_n = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!cur_rv) begin
                    rrdy_n  = 1'b0;
                    rdat_n  = '0;
                    claim_n = '0;
                    state_n = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!cur_wv) begin
                    wrdy_n  = 1'b0;
                    claim_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign idle              = (state_q == IDLE);
    assign claim_oh          = claim_q;
    assign read_ready        = rrdy_q;
    assign read_data         = rdat_q;
    assign write_ready       = wrdy_q;
    assign mem_read_valid    = mrv_q;
    assign mem_read_address  = mra_q;
    assign mem_write_valid   = mwv_q;
    assign mem_write_address = mwa_q;
    assign mem_write_data    = mwd_q;
endmodule

module mem_request_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input logic                 clk,
    input logic                 reset,
    mem_request_arbiter_if.slave bus
);
    logic [NUM_CHANNELS-1:0]                    chan_idle, ch_rrdy, ch_wrdy;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] grant, claim;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]     ch_rdat, mrd, mwd;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]     mra, mwa;
    logic [NUM_CHANNELS-1:0]                    mrv, mwv;
    logic [NUM_CONSUMERS-1:0]                   claimed, avail, req;
    logic                                       taken;

    assign req = bus.consumer_read_valid
               | ((WRITE_ENABLE != 0) ? bus.consumer_write_valid : '0);

    always_comb begin
        claimed = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) claimed = claimed | claim[c];
    end

    // Channels pick in index order; a consumer granted to a lower channel
    // this cycle is masked out of avail before higher channels look.
    always_comb begin
        avail = ~claimed;
        grant = '0;
        taken = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            taken = 1'b0;
            if (chan_idle[c]) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    if (!taken && avail[k] && req[k]) begin
                        grant[c][k] = 1'b1;
                        taken       = 1'b1;
                    end
                end
            end
            avail = avail & ~grant[c];
        end
    end

    assign mrd = bus.mem_read_data;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        mem_request_arbiter_channel #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .WRITE_ENABLE  (WRITE_ENABLE)
        ) u_chan (
            .clk                    (clk),
            .reset                  (reset),
            .grant_oh               (grant[c]),
            .consumer_read_valid    (bus.consumer_read_valid),
            .consumer_read_address  (bus.consumer_read_address),
            .consumer_write_valid   (bus.consumer_write_valid),
            .consumer_write_address (bus.consumer_write_address),
            .consumer_write_data    (bus.consumer_write_data),
            .idle                   (chan_idle[c]),
            .claim_oh               (claim[c]),
            .read_ready             (ch_rrdy[c]),
            .read_data              (ch_rdat[c]),
            .write_ready            (ch_wrdy[c]),
            .mem_read_valid         (mrv[c]),
            .mem_read_address       (mra[c]),
            .mem_read_ready         (bus.mem_read_ready[c]),
            .mem_read_data          (mrd[c]),
            .mem_write_valid        (mwv[c]),
            .mem_write_address      (mwa[c]),
            .mem_write_data         (mwd[c]),
            .mem_write_ready        (bus.mem_write_ready[c])
        );
    end

    assign bus.mem_read_valid    = mrv;
    assign bus.mem_read_address  = mra;
    assign bus.mem_write_valid   = mwv;
    assign bus.mem_write_address = mwa;
    assign bus.mem_write_data    = mwd;

    // A consumer is owned by at most one channel, so OR-merging is safe.
    logic [NUM_CONSUMERS-1:0]           cr_rdy, cw_rdy;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] cr_dat;

    always_comb begin
        cr_rdy = '0;
        cw_rdy = '0;
        cr_dat = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (claim[c][k]) begin
                    cr_rdy[k] = cr_rdy[k] | ch_rrdy[c];
                    cw_rdy[k] = cw_rdy[k] | ch_wrdy[c];
                    cr_dat[k*DATA_BITS +: DATA_BITS] =
                        cr_dat[k*DATA_BITS +: DATA_BITS] | ch_rdat[c];
                end
            end
        end
    end

    assign bus.consumer_read_ready  = cr_rdy;
    assign bus.consumer_read_data   = cr_dat;
    assign bus.consumer_write_ready = cw_rdy;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter
//   Two arbiters side by side: u1 with one channel, u2 with two channels.
//   Consumer index i = dut*4 + k; memory channel g: 0 = u1 ch0, 1/2 = u2 ch0/1.
//   A behavioural memory answers each channel after a programmable stall.
module tb_mem_request_arbiter;
    logic clk, reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_request_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) if1 ();
    mem_request_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) if2 ();

    mem_request_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1))
        u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    mem_request_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1))
        u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    // Consumer-side stimulus and observation.
    logic [7:0]  rv, wv;
    logic [63:0] ra, wa, wdat;
    logic [7:0]  rr, wr_rdy;
    logic [63:0] rdat;
    assign if1.consumer_read_valid    = rv[3:0];
    assign if2.consumer_read_valid    = rv[7:4];
    assign if1.consumer_read_address  = ra[31:0];
    assign if2.consumer_read_address  = ra[63:32];
    assign if1.consumer_write_valid   = wv[3:0];
    assign if2.consumer_write_valid   = wv[7:4];
    assign if1.consumer_write_address = wa[31:0];
    assign if2.consumer_write_address = wa[63:32];
    assign if1.consumer_write_data    = wdat[31:0];
    assign if2.consumer_write_data    = wdat[63:32];
    assign rr     = {if2.consumer_read_ready, if1.consumer_read_ready};
    assign wr_rdy = {if2.consumer_write_ready, if1.consumer_write_ready};
    assign rdat   = {if2.consumer_read_data, if1.consumer_read_data};

    // Memory side.
    logic [2:0]  m_rv, m_wv, m_rr, m_wr;
    logic [23:0] m_ra, m_wa, m_wd, m_rd;
    assign m_rv = {if2.mem_read_valid, if1.mem_read_valid};
    assign m_wv = {if2.mem_write_valid, if1.mem_write_valid};
    assign m_ra = {if2.mem_read_address, if1.mem_read_address};
    assign m_wa = {if2.mem_write_address, if1.mem_write_address};
    assign m_wd = {if2.mem_write_data, if1.mem_write_data};
    assign if1.mem_read_ready  = m_rr[0];
    assign if2.mem_read_ready  = m_rr[2:1];
    assign if1.mem_read_data   = m_rd[7:0];
    assign if2.mem_read_data   = m_rd[23:8];
    assign if1.mem_write_ready = m_wr[0];
    assign if2.mem_write_ready = m_wr[2:1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory model state.
    logic [7:0] mem [2][256];
    int         stall = 0;
    logic [2:0] never = '0, stray = '0;
    int         rcnt [3], wcnt [3], wcyc [3];
    logic [7:0] last_wa [3], last_wd [3];
    logic [7:0] rq [3][$];
    int         rs [3][$];

    initial begin
        logic [2:0] prv, pwv;
        int d;
        for (int dd = 0; dd < 2; dd++)
            for (int a = 0; a < 256; a++) mem[dd][a] = 8'(a) ^ 8'hA5;
        mem[0][8'h1F] = 8'h5A;
        mem[0][8'h10] = 8'h11;
        mem[0][8'h30] = 8'h33;
        mem[1][8'h80] = 8'hE0;
        mem[1][8'h81] = 8'hE1;
        mem[1][8'h82] = 8'hE2;
        mem[1][8'h83] = 8'hE3;
        for (int g = 0; g < 3; g++) begin
            rcnt[g] = 0; wcnt[g] = 0; wcyc[g] = 0; last_wa[g] = '0; last_wd[g] = '0;
        end
        m_rr = '0; m_wr = '0; m_rd = '0; prv = '0; pwv = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                d = (g == 0) ? 0 : 1;
                if (m_rv[g] && !prv[g]) begin
                    rq[g].push_back(m_ra[g*8 +: 8]);
                    rs[g].push_back(cyc);
                end
                if (stray[g]) begin
                    m_rr[g] = 1'b1;
                    m_rd[g*8 +: 8] = 8'hFF;
                end else if (m_rv[g] && !never[g] && rcnt[g] >= stall) begin
                    m_rr[g] = 1'b1;
                    m_rd[g*8 +: 8] = mem[d][m_ra[g*8 +: 8]];
                    rcnt[g] = 0;
                end else begin
                    m_rr[g] = 1'b0;
                    rcnt[g] = m_rv[g] ? rcnt[g] + 1 : 0;
                end
                if (m_wv[g] && !pwv[g]) wcyc[g] = 0;
                if (m_wv[g]) wcyc[g]++;
                if (m_wv[g] && wcnt[g] >= stall) begin
                    m_wr[g] = 1'b1;
                    mem[d][m_wa[g*8 +: 8]] = m_wd[g*8 +: 8];
                    last_wa[g] = m_wa[g*8 +: 8];
                    last_wd[g] = m_wd[g*8 +: 8];
                    wcnt[g] = 0;
                end else begin
                    m_wr[g] = 1'b0;
                    wcnt[g] = m_wv[g] ? wcnt[g] + 1 : 0;
                end
            end
            prv = m_rv;
            pwv = m_wv;
        end
    end

    // Scoreboard: one queue of expected responses per consumer.
    typedef struct { bit wr; logic [7:0] data; } exp_t;
    exp_t exp_q [8][$];

    initial begin
        logic [7:0] prr, pwr;
        logic [7:0] sv [8];
        exp_t e;
        prr = '0; pwr = '0;
        for (int i = 0; i < 8; i++) sv[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < 8; i++) begin
                    if (rr[i] && !prr[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++; failures++;
                            $display("FAIL spurious_read_ready consumer=%0d actual=1 expected=0", i);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk("resp_kind_read", 64'(e.wr), 64'd0);
                            chk("read_data", rdat[i*8 +: 8], e.data);
                        end
                        sv[i] = rdat[i*8 +: 8];
                    end else if (rr[i] && prr[i]) begin
                        chk("read_data_stable", rdat[i*8 +: 8], sv[i]);
                    end
                    if (wr_rdy[i] && !pwr[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++; failures++;
                            $display("FAIL spurious_write_ready consumer=%0d actual=1 expected=0", i);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk("resp_kind_write", 64'(e.wr), 64'd1);
                        end
                    end
                end
            end
            prr = rr;
            pwr = wr_rdy;
        end
    end

    // Requester: raise valid, wait for ready, drop valid the next cycle.
    task automatic do_req(input int d, input int k, input bit wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] ed, output int lat);
        exp_t e;
        int   i;
        bit   seen;
        i = d*4 + k;
        e.wr = wr;
        e.data = ed;
        exp_q[i].push_back(e);
        if (wr) begin
            wa[i*8 +: 8] = a; wdat[i*8 +: 8] = wd; wv[i] = 1'b1;
        end else begin
            ra[i*8 +: 8] = a; rv[i] = 1'b1;
        end
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            seen = wr ? wr_rdy[i] : rr[i];
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL req_timeout consumer=%0d actual=no_ready expected=ready", i);
        end
        @(negedge clk);
        chk("ready_held", 64'(wr ? wr_rdy[i] : rr[i]), 64'd1);
        if (wr) wv[i] = 1'b0; else rv[i] = 1'b0;
        @(negedge clk);
        chk("ready_released", 64'(wr ? wr_rdy[i] : rr[i]), 64'd0);
        chk("data_released", rdat[i*8 +: 8], 64'd0);
    endtask

    task automatic chk_dut0_zero(input string name);
        chk(name, {rr[3:0], wr_rdy[3:0], rdat[31:0], m_rv[0], m_wv[0], m_ra[7:0], m_wa[7:0], m_wd[7:0]}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1, l3;
        int lt [4];
        reset = 1'b1;
        rv = '0; wv = '0; ra = '0; wa = '0; wdat = '0;
        repeat (3) @(negedge clk);
        chk("rst_consumer", {rr, wr_rdy}, 64'd0);
        chk("rst_rdata", rdat, 64'd0);
        chk("rst_mem", {m_rv, m_wv, m_ra, m_wa}, 64'd0);
        chk("rst_wdata", m_wd, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read: consumer 2, addr 0x1F -> 0x5A.
        rq[0].delete();
        do_req(0, 2, 1'b0, 8'h1F, 8'h00, 8'h5A, l1);
        chk("read_latency", l1, 2);
        chk("read_mem_addr", rq[0].size() == 1 ? rq[0][0] : 8'hXX, 8'h1F);
        chk_dut0_zero("read_idle_zero");

        // Single write with stall: valid held 3 cycles.
        stall = 2;
        do_req(0, 0, 1'b1, 8'h40, 8'hC3, 8'h00, l1);
        stall = 0;
        chk("write_latency", l1, 4);
        chk("write_valid_cycles", wcyc[0], 3);
        chk("write_addr", last_wa[0], 8'h40);
        chk("write_data", last_wd[0], 8'hC3);
        chk("write_mem", mem[0][8'h40], 8'hC3);
        chk_dut0_zero("write_idle_zero");

        // Contention on one channel: consumer 1 before consumer 3.
        rq[0].delete();
        fork
            do_req(0, 1, 1'b0, 8'h10, 8'h00, 8'h11, l1);
            do_req(0, 3, 1'b0, 8'h30, 8'h00, 8'h33, l3);
        join
        chk("cont_lat_c1", l1, 2);
        chk("cont_lat_c3", l3, 6);
        chk("cont_count", rq[0].size(), 2);
        chk("cont_first", rq[0][0], 8'h10);
        chk("cont_second", rq[0][1], 8'h30);

        // Two channels, four simultaneous reads.
        for (int g = 1; g < 3; g++) begin rq[g].delete(); rs[g].delete(); end
        fork
            do_req(1, 0, 1'b0, 8'h80, 8'h00, 8'hE0, lt[0]);
            do_req(1, 1, 1'b0, 8'h81, 8'h00, 8'hE1, lt[1]);
            do_req(1, 2, 1'b0, 8'h82, 8'h00, 8'hE2, lt[2]);
            do_req(1, 3, 1'b0, 8'h83, 8'h00, 8'hE3, lt[3]);
        join
        chk("dual_lat0", lt[0], 2);
        chk("dual_lat1", lt[1], 2);
        chk("dual_lat2", lt[2], 6);
        chk("dual_lat3", lt[3], 6);
        chk("dual_ch0_cnt", rq[1].size(), 2);
        chk("dual_ch1_cnt", rq[2].size(), 2);
        chk("dual_ch0_a", rq[1][0], 8'h80);
        chk("dual_ch1_a", rq[2][0], 8'h81);
        chk("dual_ch0_b", rq[1][1], 8'h82);
        chk("dual_ch1_b", rq[2][1], 8'h83);
        chk("dual_same_cycle", rs[1][0], rs[2][0]);

        // Reset while waiting on a memory that never answers.
        never[0] = 1'b1;
        ra[2*8 +: 8] = 8'h77;
        rv[2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rw_mem_valid", m_rv[0], 1);
        chk("rw_mem_addr", m_ra[7:0], 8'h77);
        chk("rw_no_ready", rr[2], 0);
        reset = 1'b1;
        rv[2] = 1'b0;
        @(negedge clk);
        chk_dut0_zero("rw_reset_zero");
        reset = 1'b0;
        never[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk_dut0_zero("rw_after_reset");
        do_req(0, 2, 1'b0, 8'h20, 8'h00, 8'h85, l1);
        chk("rw_regrant_lat", l1, 2);

        // Stray memory ready while idle.
        stray[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("stray_no_resp", {rr[3:0], rdat[31:0]}, 64'd0);
            chk("stray_idle", m_rv[0], 0);
        end
        stray[0] = 1'b0;
        @(negedge clk);
        do_req(0, 1, 1'b0, 8'h05, 8'h00, 8'hA0, l1);
        chk("stray_then_read_lat", l1, 2);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) chk("scoreboard_empty", exp_q[i].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Responder-side memory controller that serves per-thread load/store requesters.
- Accepts valid/ready read and write requests from NUM_CONSUMERS requesters and arbitrates them onto NUM_CHANNELS external memory channels.
- Relays memory responses back to the requester that issued them.
- Sits between all cores' load/store units and the external data memory interface.

Parameters:
- ADDR_BITS, 8, address width on both sides.
- DATA_BITS, 8, data width on both sides.
- NUM_CONSUMERS, 4, number of requesters served (flattened port vectors).
- NUM_CHANNELS, 1, number of concurrent external memory channels.
- WRITE_ENABLE, 1: if 0, write requests are never granted and all write outputs stay 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-requester read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  read address; consumer k occupies bits [k*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  read response valid
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  read response data
- consumer_write_valid  in  NUM_CONSUMERS  per-requester write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write acknowledge
- mem_read_valid  out  NUM_CHANNELS  memory read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  memory read address
- mem_read_ready  in  NUM_CHANNELS  memory read data valid
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  memory write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  memory write address
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  memory write data
- mem_write_ready  in  NUM_CHANNELS  memory write acknowledge

Behaviour:
- Reset (sync, active-high):
  - All outputs driven to 0.
  - Every channel returns to IDLE; all consumer claims cleared.
  - Reset mid-transaction abandons the transfer; no response is produced afterwards.
- State per channel: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING. Each channel records current_consumer.
- Requester contract:
  - Holds valid/address/data stable until it sees ready=1.
  - Drops valid on the cycle after seeing ready.
  - At most one outstanding request per requester.
- IDLE grant:
  - Channel scans consumers 0..NUM_CONSUMERS-1 and picks the lowest index that has read_valid or write_valid and is not claimed.
  - Channels are evaluated in index order within a cycle. A consumer claimed by channel c in cycle t is invisible to channels >c in the same cycle, so no double grant.
  - Read grant: claim consumer, register mem_read_valid=1 and mem_read_address=consumer address, go to READ_WAITING.
  - Write grant (WRITE_ENABLE=1): claim consumer, register mem_write_valid=1 plus address and data, go to WRITE_WAITING.
  - If read_valid and write_valid are both high on one consumer, read is granted first.
- READ_WAITING:
  - Holds the request until mem_read_ready=1.
  - Then, registered: mem_read_valid=0, consumer_read_ready[k]=1, consumer_read_data[k]=mem_read_data; go to READ_RELAYING.
- WRITE_WAITING:
  - Holds the request until mem_write_ready=1.
  - Then: mem_write_valid=0, consumer_write_ready[k]=1; go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Ready stays 1 and data stays stable while the consumer valid is 1.
  - When the consumer valid=0: ready=0, claim released, go to IDLE.
  - The consumer is re-grantable no earlier than the following cycle.
- Latency, single channel, memory ready on first opportunity:
  - Valid at t → mem valid at t+1 → mem ready sampled at t+1 → consumer ready at t+2 → consumer drops valid at t+3 → ready=0 and IDLE at t+4.
- Other rules:
  - Fixed priority; starvation is acceptable because each requester has one outstanding access per instruction.
  - mem_*_ready while the channel is not in the matching WAITING state is ignored.
  - No arithmetic: addresses and data pass through unmodified at full width.

Test Plan:
- Single read: consumer 2 reads addr 0x1F, memory returns 0x5A one cycle after mem_read_valid → mem_read_address=0x1F, consumer_read_data[2]=0x5A with ready high until valid drops, then all zeros.
- Single write: consumer 0 writes 0xC3 to 0x40, memory ready after 3-cycle stall → mem_write_valid held 3 cycles with addr 0x40 / data 0xC3, then consumer_write_ready[0] pulse-holds until valid drops.
- Contention, NUM_CHANNELS=1: consumers 1 and 3 request reads (0x10, 0x30) in the same cycle → consumer 1 served first; consumer 3's request issues only after channel returns to IDLE; each gets its own data.
- Two channels, four simultaneous reads → channel 0 takes consumer 0, channel 1 takes consumer 1 in the same cycle, no consumer granted twice; consumers 2 and 3 served next.
- Reset during READ_WAITING (mem never ready) → all outputs 0 the following cycle; a later request from the same consumer is granted normally.
- Stray mem_read_ready=1 while the channel is IDLE → no consumer_read_ready asserted, state unchanged.
